// File: rtl/stl_rshift_pkg.sv
// Shared types and the round-robin search helper for the rotate arbiter.
package stl_rshift_pkg;

    localparam int unsigned RR_MAX = 8;
    localparam int unsigned RR_W   = 3;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_e;

    typedef struct packed {
        logic            found;
        logic [RR_W-1:0] idx;
    } rr_pick_t;

    // Unused requesters are zero-padded, so wrapping mod RR_MAX
    // gives the same winner as wrapping mod NREQ.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX-1:0] vld,
        input logic [RR_W-1:0]   ptr
    );
        rr_pick_t        r;
        logic [RR_W-1:0] k;
        r = '0;
        for (int i = 0; i < RR_MAX; i++) begin
            k = ptr + RR_W'(i);
            if (!r.found && vld[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stl_rot_core.sv
// Combinational left rotator: out lane j = in lane (j - sht) mod DIM_N.
module stl_rot_core #(
    parameter int DIM_N = 16,
    parameter int DAT_W = 10,
    parameter int SHT_W = 4
) (
    input  logic [DIM_N-1:0][DAT_W-1:0] dat_i,
    input  logic [SHT_W-1:0]            sht_i,
    output logic [DIM_N-1:0][DAT_W-1:0] dat_o
);

    always_comb begin
        dat_o = '0;
        for (int j = 0; j < DIM_N; j++) begin
            dat_o[j] = dat_i[SHT_W'(j) - sht_i];
        end
    end

endmodule

// File: rtl/stl_rshift_arb.sv
// Round-robin shared rotate unit with a registered result stage.
// Optional burst lock enabled by macro STL_RSHIFT_ARB_LOCK_EN.
module stl_rshift_arb
    import stl_rshift_pkg::*;
#(
    parameter int DIM_N = 16,
    parameter int DAT_W = 10,
    parameter int SHT_W = 4,
    parameter int NREQ  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NREQ-1:0]                        req_vld,
    output logic [NREQ-1:0]                        req_rdy,
    input  logic [NREQ-1:0][DIM_N-1:0][DAT_W-1:0]  req_dat,
    input  logic [NREQ-1:0][SHT_W-1:0]             req_sht,
    input  logic [NREQ-1:0]                        req_dir,
    input  logic [NREQ-1:0]                        req_lock,
    output logic                                   rsp_vld,
    input  logic                                   rsp_rdy,
    output logic [DIM_N-1:0][DAT_W-1:0]            rsp_dat,
    output logic [$clog2(NREQ)-1:0]                rsp_id
);

    localparam int ID_W = $clog2(NREQ);

    logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic                       rsp_vld_q;
    logic [DIM_N-1:0][DAT_W-1:0] rsp_dat_q;
    logic [ID_W-1:0]            rsp_id_q;

    rr_pick_t                   pick;
    logic [ID_W-1:0]            gnt;
    logic [ID_W-1:0]            gnt_nxt;
    logic                       out_free;
    logic                       acc;
    logic [DIM_N-1:0][DAT_W-1:0] sel_dat;
    logic [DIM_N-1:0][DAT_W-1:0] rot_dat;
    logic [SHT_W-1:0]           sel_sht;
    logic [SHT_W-1:0]           rot_amt;
    dir_e                       sel_dir;
    logic                       unused_bits;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] p);
        return (p == ID_W'(NREQ - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_free = !rsp_vld_q || rsp_rdy;
    assign pick     = rr_pick(RR_MAX'(req_vld), RR_W'(rr_ptr_q));
    assign gnt      = ID_W'(pick.idx);
    assign gnt_nxt  = wrap_inc(gnt);
    assign acc      = !rst && pick.found && out_free;

    always_comb begin
        req_rdy = '0;
        if (acc) req_rdy[gnt] = 1'b1;
    end

    assign sel_dat = req_dat[gnt];
    assign sel_sht = req_sht[gnt];
    assign sel_dir = dir_e'(req_dir[gnt]);
    // Right rotate is a left rotate by (DIM_N - sht) mod DIM_N.
    assign rot_amt = (sel_dir == RIGHT) ? SHT_W'(DIM_N) - sel_sht : sel_sht;

    stl_rot_core #(
        .DIM_N (DIM_N),
        .DAT_W (DAT_W),
        .SHT_W (SHT_W)
    ) u_rot (
        .dat_i (sel_dat),
        .sht_i (rot_amt),
        .dat_o (rot_dat)
    );

`ifdef STL_RSHIFT_ARB_LOCK_EN
    logic            lock_q, lock_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;

    assign unused_bits = ^pick.idx;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (acc) begin
            if (req_lock[gnt]) begin
                rr_ptr_d  = gnt;
                lock_d    = 1'b1;
                lock_id_d = gnt;
            end else begin
                rr_ptr_d  = gnt_nxt;
                lock_d    = 1'b0;
            end
        end else if (lock_q && !req_vld[lock_id_q]) begin
            // Owner dropped out: give up priority as if it had been served.
            rr_ptr_d = wrap_inc(lock_id_q);
            lock_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end
`else
    assign unused_bits = ^{req_lock, pick.idx};

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (acc) rr_ptr_d = gnt_nxt;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_id_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (acc) begin
                rsp_vld_q <= 1'b1;
                rsp_dat_q <= rot_dat;
                rsp_id_q  <= gnt;
            end else if (rsp_rdy) begin
                rsp_vld_q <= 1'b0;
            end
        end
    end

    assign rsp_vld = rsp_vld_q;
    assign rsp_dat = rsp_dat_q;
    assign rsp_id  = rsp_id_q;

endmodule

// File: tb/tb_stl_rshift_arb.sv
// Directed and random checks of stl_rshift_arb against a rule-level model.
module tb_stl_rshift_arb;

    localparam int DIM_N = 16;
    localparam int DAT_W = 10;
    localparam int SHT_W = 4;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int VW    = DIM_N * DAT_W;

    typedef logic [DIM_N-1:0][DAT_W-1:0] vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [NREQ-1:0] req_vld, req_rdy, req_dir, req_lock;
    logic [NREQ-1:0][DIM_N-1:0][DAT_W-1:0] req_dat;
    logic [NREQ-1:0][SHT_W-1:0] req_sht;
    logic rsp_vld, rsp_rdy;
    vec_t rsp_dat;
    logic [ID_W-1:0] rsp_id;

    int checks = 0;
    int errors = 0;

    int   m_ptr = 0;
    bit   m_vld = 1'b0;
    vec_t m_dat = '0;
    int   m_id  = 0;
    bit   m_lock = 1'b0;
    int   m_lid = 0;

    stl_rshift_arb #(
        .DIM_N (DIM_N),
        .DAT_W (DAT_W),
        .SHT_W (SHT_W),
        .NREQ  (NREQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_rdy  (req_rdy),
        .req_dat  (req_dat),
        .req_sht  (req_sht),
        .req_dir  (req_dir),
        .req_lock (req_lock),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_dat  (rsp_dat),
        .rsp_id   (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs,
                       input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t rotate(input vec_t v, input int sht, input bit right);
        vec_t r;
        for (int j = 0; j < DIM_N; j++) begin
            if (right) r[j] = v[(j + sht) % DIM_N];
            else       r[j] = v[(j - sht + DIM_N) % DIM_N];
        end
        return r;
    endfunction

    function automatic int pick_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (req_vld[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // One clock: inputs are already driven after a falling edge.
    task automatic cycle();
        int g;
        logic [NREQ-1:0] exp_rdy;
        bit free;
        #1;
        free = !m_vld || rsp_rdy;
        g = pick_winner();
        exp_rdy = '0;
        if (!rst && free && g >= 0) exp_rdy[g] = 1'b1;
        chk("req_rdy", VW'(req_rdy), VW'(exp_rdy));
        @(posedge clk);
        if (rst) begin
            m_vld = 1'b0; m_dat = '0; m_id = 0; m_ptr = 0; m_lock = 1'b0;
        end else if (exp_rdy != '0) begin
            m_vld = 1'b1;
            m_dat = rotate(req_dat[g], int'(req_sht[g]), req_dir[g]);
            m_id  = g;
`ifdef STL_RSHIFT_ARB_LOCK_EN
            if (req_lock[g]) begin
                m_ptr = g; m_lock = 1'b1; m_lid = g;
            end else begin
                m_ptr = (g + 1) % NREQ; m_lock = 1'b0;
            end
`else
            m_ptr = (g + 1) % NREQ;
`endif
        end else begin
            if (rsp_rdy) m_vld = 1'b0;
`ifdef STL_RSHIFT_ARB_LOCK_EN
            if (m_lock && !req_vld[m_lid]) begin
                m_lock = 1'b0; m_ptr = (m_lid + 1) % NREQ;
            end
`endif
        end
        #1;
        chk("rsp_vld", VW'(rsp_vld), VW'(m_vld));
        chk("rsp_id", VW'(rsp_id), VW'(m_id));
        chk("rsp_dat", rsp_dat, m_dat);
        @(negedge clk);
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < DIM_N; j++) req_dat[i][j] = DAT_W'($urandom);
            req_sht[i] = SHT_W'($urandom);
        end
        req_dir = NREQ'($urandom);
    endtask

    initial begin
        vec_t exp_v;
        vec_t held_dat;
        logic [ID_W-1:0] held_id;

        rst = 1'b1; req_vld = '1; rsp_rdy = 1'b0;
        req_dat = '0; req_sht = '0; req_dir = '0; req_lock = '0;
        @(negedge clk);
        cycle();
        cycle();
        chk("reset_vld", VW'(rsp_vld), VW'(0));

        // Single request, left rotate by 3.
        rst = 1'b0; rsp_rdy = 1'b1; req_vld = 4'b0100;
        for (int j = 0; j < DIM_N; j++) req_dat[2][j] = DAT_W'(j);
        req_sht[2] = 4'd3; req_dir[2] = 1'b0;
        cycle();
        for (int j = 0; j < DIM_N; j++) exp_v[j] = DAT_W'((j - 3) & 15);
        chk("lat_id", VW'(rsp_id), VW'(2));
        chk("lat_left3", rsp_dat, exp_v);

        // Right rotate by 3, then amount 0 in both directions.
        req_vld = 4'b0001;
        for (int j = 0; j < DIM_N; j++) req_dat[0][j] = DAT_W'(j);
        req_sht[0] = 4'd3; req_dir[0] = 1'b1;
        cycle();
        for (int j = 0; j < DIM_N; j++) exp_v[j] = DAT_W'((j + 3) & 15);
        chk("right3", rsp_dat, exp_v);
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < DIM_N; j++) req_dat[0][j] = DAT_W'($urandom);
            req_sht[0] = '0; req_dir[0] = d[0];
            cycle();
            chk("sht0_pass", rsp_dat, req_dat[0]);
        end

        // Fairness with all requesters valid.
        rst = 1'b1; req_vld = '0;
        cycle();
        rst = 1'b0; req_vld = '1;
        for (int k = 0; k < 8; k++) begin
            rand_data();
            cycle();
            chk("rr_order", VW'(rsp_id), VW'(k % 4));
            chk("rr_nobubble", VW'(rsp_vld), VW'(1));
        end

        // Backpressure: result held, no grants, pointer kept.
        rsp_rdy = 1'b0;
        held_dat = rsp_dat; held_id = rsp_id;
        for (int k = 0; k < 5; k++) begin
            rand_data();
            cycle();
            chk("bp_dat", rsp_dat, held_dat);
            chk("bp_id", VW'(rsp_id), VW'(held_id));
        end
        rsp_rdy = 1'b1;
        cycle();
        chk("bp_resume", VW'(rsp_id), VW'(0));

        // Reset while a result is pending.
        rsp_rdy = 1'b0; rst = 1'b1;
        cycle();
        chk("midrst_vld", VW'(rsp_vld), VW'(0));
        rst = 1'b0; req_vld = '0; rsp_rdy = 1'b1;
        cycle();
        chk("postrst_idle", VW'(rsp_vld), VW'(0));
        req_vld = 4'b1001;
        cycle();
        chk("postrst_gnt", VW'(rsp_id), VW'(0));

`ifdef STL_RSHIFT_ARB_LOCK_EN
        rst = 1'b1; req_vld = '0;
        cycle();
        rst = 1'b0; req_vld = '1; req_lock = '0;
        cycle();
        req_lock = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("lock_hold", VW'(rsp_id), VW'(1));
        end
        req_lock = '0;
        cycle();
        chk("lock_last", VW'(rsp_id), VW'(1));
        cycle();
        chk("lock_next", VW'(rsp_id), VW'(2));
`endif

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 99) < 3);
            req_vld  = NREQ'($urandom);
            req_lock = NREQ'($urandom);
            rsp_rdy  = ($urandom_range(0, 99) < 70);
            rand_data();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stl_rshift_arb.md
STL_RSHIFT_ARB -- requirements
Module: stl_rshift_arb

Interface
REQ-001 SHALL have parameter DIM_N, default 16, meaning the number of lanes per vector; it must be a power of two.
REQ-002 SHALL have parameter DAT_W, default 10, meaning the width of each lane.
REQ-003 SHALL have parameter SHT_W, default 4, meaning the shift-amount width; it SHALL equal log2(DIM_N).
REQ-004 SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port req_vld, input, [NREQ-1:0]: per-requester valid.
REQ-008 SHALL have port req_rdy, output, [NREQ-1:0]: per-requester ready, one-hot or zero.
REQ-009 SHALL have port req_dat, input, [NREQ-1:0][DIM_N-1:0][DAT_W-1:0]: per-requester vector.
REQ-010 SHALL have port req_sht, input, [NREQ-1:0][SHT_W-1:0]: per-requester rotate amount.
REQ-011 SHALL have port req_dir, input, [NREQ-1:0]: 0 = left rotate, 1 = right rotate.
REQ-012 SHALL have port req_lock, input, [NREQ-1:0]: burst lock hint; used only with the macro in REQ-032.
REQ-013 SHALL have port rsp_vld, output, 1 bit: result valid.
REQ-014 SHALL have port rsp_rdy, input, 1 bit: downstream ready.
REQ-015 SHALL have port rsp_dat, output, [DIM_N-1:0][DAT_W-1:0]: rotated vector.
REQ-016 SHALL have port rsp_id, output, [$clog2(NREQ)-1:0]: index of the requester that owns the result.

Function
REQ-017 SHALL share a single rotate datapath among the NREQ requesters, granting at most one requester per cycle.
REQ-018 SHALL use round-robin arbitration: search starts at pointer rr_ptr; the lowest index at or after rr_ptr (with wrap) that has req_vld=1 wins.
REQ-019 SHALL set req_rdy[g]=1 only for the winner g, and only when the output stage is free, i.e. rsp_vld=0 or rsp_rdy=1 in the same cycle.
REQ-020 SHALL treat a request as accepted on a cycle where req_vld[g] and req_rdy[g] are both 1; on acceptance, rr_ptr SHALL become (g+1) mod NREQ.
REQ-021 SHALL NOT let req_rdy depend combinationally on req_rdy of any other requester; req_rdy MAY depend on req_vld and rsp_rdy.
REQ-022 SHALL implement right rotate as left rotate by (DIM_N - req_sht) mod DIM_N, so that amount 0 passes data through unchanged in both directions.
REQ-023 SHALL compute the rotation so that a left rotate gives out lane j = in lane (j - sht) mod DIM_N.
REQ-024 SHALL register the result: rsp_dat and rsp_id are updated, and rsp_vld=1, in cycle N+1 for a request accepted in cycle N (latency 1).
REQ-025 SHALL hold rsp_vld, rsp_dat and rsp_id stable while rsp_vld=1 and rsp_rdy=0.
REQ-026 SHALL clear rsp_vld when rsp_rdy=1 and there is no acceptance in the same cycle.
REQ-027 SHALL support simultaneous drain and accept: with rsp_vld=1, rsp_rdy=1 and a new acceptance, the new result SHALL load with no bubble, giving a sustained throughput of 1 per cycle.
REQ-028 SHALL keep rr_ptr unchanged when no request is accepted, including under backpressure.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, force rsp_vld=0, rsp_dat=0, rsp_id=0, rr_ptr=0 and clear any lock state.
REQ-030 SHALL drive req_rdy=0 during any cycle in which rst=1, so that no acceptance occurs during reset.
REQ-031 SHALL, when reset is asserted mid-transfer, discard a pending result that has not yet been taken; no rsp_vld SHALL appear after reset until a new acceptance.

Configuration
REQ-032 SHALL, when macro STL_RSHIFT_ARB_LOCK_EN is defined, behave as follows: after an acceptance from g with req_lock[g]=1, g keeps priority and rr_ptr holds g until an acceptance from g with req_lock[g]=0, or until req_vld[g]=0 for one cycle.
REQ-033 SHALL, when STL_RSHIFT_ARB_LOCK_EN is undefined, ignore req_lock, build no lock state, and behave as pure round-robin.

Structure
REQ-034 SHALL place the following in shared package stl_rshift_pkg: typedef dir_e (LEFT=0, RIGHT=1), and function rr_pick(vld, ptr) returning the grant index plus a found flag.
REQ-035 SHALL instantiate one sub-module, stl_rot_core, a combinational left rotator taking DIM_N, DAT_W and SHT_W; arbitration, direction conversion and the output register stay in stl_rshift_arb.

Verification
REQ-036 SHALL check single-request latency: NREQ=4, only req 2 valid, DIM_N=16, lanes = lane index, sht=3, dir=0 -> next cycle rsp_vld=1, rsp_id=2, out lane j = (j-3) mod 16.
REQ-037 SHALL check right rotate: req 0, sht=3, dir=1 -> out lane j = (j+3) mod 16; sht=0 with either dir -> output equals input.
REQ-038 SHALL check round-robin fairness: all 4 valid continuously, rsp_rdy=1 -> grant order 0,1,2,3,0,... with one result per cycle and no bubbles.
REQ-039 SHALL check backpressure: rsp_rdy=0 for 5 cycles with results pending -> rsp_dat/rsp_id stable, req_rdy=0, rr_ptr unchanged; releasing rsp_rdy resumes with the next round-robin winner.
REQ-040 SHALL check reset mid-transfer: rst=1 with rsp_vld=1 -> the next cycle has rsp_vld=0 and rr_ptr=0, and the first grant after reset goes to the lowest valid index.
REQ-041 SHALL check the lock feature, with STL_RSHIFT_ARB_LOCK_EN defined: req 1 with req_lock=1 for 3 beats while all requesters are valid -> grants 1,1,1, then on the beat with lock=0 -> grant 1, then 2.
